// File: rtl/arb_pkg.sv
// Shared types and constants for the unified IF/MEM memory bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  localparam logic [1:0]  GRANT_NONE    = 2'b00;
  localparam logic [1:0]  GRANT_IF      = 2'b01;
  localparam logic [1:0]  GRANT_MEM     = 2'b10;
  localparam logic [1:0]  SIZE_WORD     = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/arb_wait_timer.sv
// Bus wait-state counter: counts cycles without m_ack_n, flags the cycle that reaches
// BUS_TIMEOUT. BUS_TIMEOUT = 0 removes the counter entirely.
module arb_wait_timer #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (BUS_TIMEOUT > 0) begin : g_timer
    localparam int unsigned CntW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BUS_TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(BUS_TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Fires on the wait cycle whose increment would reach BUS_TIMEOUT.
    assign expired = enable && !clear && (cnt_q == CntLast);
  end else begin : g_no_timer
    logic unused_timer;
    assign unused_timer = ^{clk, rst, clear, enable};
    assign expired      = 1'b0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store.
// Optional ARB_STARVE_GUARD_EN bounds consecutive data grants while a fetch waits.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT    = 255,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack_n,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack_n,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack_n,
  output logic [1:0]  grant,
  output logic        bus_err
);

  arb_state_e  state_q, state_d;
  logic        m_req_q, m_req_d, m_write_q, m_write_d;
  logic [1:0]  m_size_q, m_size_d, grant_q, grant_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        i_ack_n_q, i_ack_n_d, d_ack_n_q, d_ack_n_d;
  logic        bus_err_q, bus_err_d;
  logic        busy, timer_expired, data_wins, fetch_grant, data_grant;
  logic [31:0] resp_rdata;

  assign busy = (state_q == I_BUSY) || (state_q == D_BUSY);

  arb_wait_timer #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!busy),
    .enable (busy && m_ack_n),
    .expired(timer_expired)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned BurstW = (MAX_DATA_BURST > 0) ? $clog2(MAX_DATA_BURST + 1) : 1;
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_DATA_BURST);

  logic [BurstW-1:0] burst_q, burst_d;

  always_comb begin
    burst_d = burst_q;
    if (fetch_grant) begin
      burst_d = '0;
    end else if (data_grant && i_req && (burst_q != BurstMax)) begin
      burst_d = burst_q + BurstW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_q <= '0;
    end else begin
      burst_q <= burst_d;
    end
  end

  assign data_wins = d_req && !(i_req && (burst_q == BurstMax));
`else
  localparam int unsigned unused_max_data_burst = MAX_DATA_BURST;
  assign data_wins = d_req;
`endif

  // A timed-out read returns TIMEOUT_RDATA instead of whatever floats on the bus.
  assign resp_rdata = m_ack_n ? TIMEOUT_RDATA : m_rdata;

  always_comb begin
    state_d     = state_q;
    m_req_d     = m_req_q;
    m_write_d   = m_write_q;
    m_size_d    = m_size_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    grant_d     = grant_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_n_d   = 1'b1;
    d_ack_n_d   = 1'b1;
    bus_err_d   = 1'b0;
    fetch_grant = 1'b0;
    data_grant  = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_wins) begin
          state_d    = D_BUSY;
          data_grant = 1'b1;
          m_req_d    = 1'b1;
          m_write_d  = d_write;
          m_size_d   = d_size;
          m_addr_d   = d_addr;
          m_wdata_d  = d_wdata;
          grant_d    = GRANT_MEM;
        end else if (i_req) begin
          state_d     = I_BUSY;
          fetch_grant = 1'b1;
          m_req_d     = 1'b1;
          m_write_d   = 1'b0;
          m_size_d    = SIZE_WORD;
          m_addr_d    = i_addr;
          m_wdata_d   = '0;
          grant_d     = GRANT_IF;
        end
      end
      I_BUSY, D_BUSY: begin
        if (!m_ack_n || timer_expired) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          m_write_d = 1'b0;
          grant_d   = GRANT_NONE;
          bus_err_d = timer_expired;
          if (state_q == I_BUSY) begin
            i_ack_n_d = 1'b0;
            i_rdata_d = resp_rdata;
          end else begin
            d_ack_n_d = 1'b0;
            if (!m_write_q) begin
              d_rdata_d = resp_rdata;
            end
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_req_q   <= 1'b0;
      m_write_q <= 1'b0;
      m_size_q  <= 2'b00;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      grant_q   <= GRANT_NONE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_n_q <= 1'b1;
      d_ack_n_q <= 1'b1;
      bus_err_q <= 1'b0;
    end else begin
      m_req_q   <= m_req_d;
      m_write_q <= m_write_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      grant_q   <= grant_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_n_q <= i_ack_n_d;
      d_ack_n_q <= d_ack_n_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_write = m_write_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign grant   = grant_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack_n = i_ack_n_q;
  assign d_ack_n = d_ack_n_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays both requesters and the memory bus.
module tb_mem_arbiter;

  localparam int unsigned TO = 8;
  localparam int unsigned MB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_write, m_ack_n;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack_n, d_ack_n, m_req, m_write, bus_err;
  logic [1:0]  m_size, grant;

  mem_arbiter #(
    .BUS_TIMEOUT   (TO),
    .MAX_DATA_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack_n(i_ack_n),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack_n(d_ack_n),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n),
    .grant(grant), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observations of the most recent transaction, filled in by serve().
  logic        got_req, stable, seen_i, seen_d, seen_err, both_low, ack_high;
  logic        s_write;
  logic [1:0]  s_size, s_grant;
  logic [31:0] s_addr, s_wdata;
  int          req_ticks, busy_cycles;

  // Reference model state.
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  int          burst = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as the memory: acks after 'waits' wait cycles (never if waits >= 40).
  task automatic serve(input int waits, input logic [31:0] rd, input bit drop_mid);
    int k;
    int cyc;
    k = 0;
    while (!m_req && k < 4) begin
      tick();
      k++;
    end
    req_ticks = k;
    got_req   = m_req;
    s_write   = m_write;
    s_size    = m_size;
    s_addr    = m_addr;
    s_wdata   = m_wdata;
    s_grant   = grant;
    stable    = got_req;
    if (drop_mid) begin
      i_req = 1'b0;
      d_req = 1'b0;
    end
    cyc = 0;
    while (cyc < 40) begin
      if (cyc == waits) begin
        m_ack_n = 1'b0;
        m_rdata = rd;
      end
      if ({m_req, m_write, m_size, m_addr, m_wdata, grant} !==
          {1'b1, s_write, s_size, s_addr, s_wdata, s_grant}) stable = 1'b0;
      // Idle requesters scribble on their inputs; the bus must not follow.
      if (!i_req) i_addr = $urandom;
      if (!d_req) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_size  = 2'($urandom);
      end
      tick();
      cyc++;
      m_ack_n = 1'b1;
      m_rdata = $urandom;
      if (!i_ack_n || !d_ack_n) break;
    end
    busy_cycles = cyc;
    seen_i      = !i_ack_n;
    seen_d      = !d_ack_n;
    seen_err    = bus_err;
    both_low    = !i_ack_n && !d_ack_n;
    if (seen_i) i_req = 1'b0;
    if (seen_d) d_req = 1'b0;
    tick();
    ack_high = i_ack_n && d_ack_n && !bus_err && (grant == 2'b00);
  endtask

  task automatic test_reset();
    logic [136:0] obs;
    rst = 1'b1;
    i_req = 0; d_req = 0; d_write = 0; d_size = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; m_ack_n = 1'b1;
    repeat (3) tick();
    obs = {m_req, m_write, bus_err, m_size, m_addr, m_wdata, i_rdata, d_rdata, grant,
           i_ack_n, d_ack_n};
    vectors++;
    if (obs !== {5'b0, 128'h0, 2'b00, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_values: got %h expected %h", obs, {5'b0, 128'h0, 2'b00, 2'b11});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    i_req = 1'b1;
    i_addr = 32'h100;
    serve(0, 32'h0000_0013, 1'b0);
    exp_i_rdata = 32'h0000_0013;
    burst = 0;
    vectors++;
    if (req_ticks !== 1) begin
      miscompares++; $display("FAIL fetch_latency: got %0d expected 1", req_ticks);
    end
    vectors++;
    if ({s_addr, s_write, s_size, s_grant} !== {32'h100, 1'b0, 2'b10, 2'b01}) begin
      miscompares++;
      $display("FAIL fetch_bus: got %h/%b/%b/%b expected 100/0/10/01", s_addr, s_write,
               s_size, s_grant);
    end
    vectors++;
    if ({busy_cycles, seen_i, seen_d, seen_err} !== {32'd1, 3'b100}) begin
      miscompares++;
      $display("FAIL fetch_ack: got busy=%0d i=%b d=%b err=%b expected 1/1/0/0",
               busy_cycles, seen_i, seen_d, seen_err);
    end
    vectors++;
    if (i_rdata !== exp_i_rdata) begin
      miscompares++; $display("FAIL fetch_rdata: got %h expected %h", i_rdata, exp_i_rdata);
    end
    vectors++;
    if (ack_high !== 1'b1) begin
      miscompares++; $display("FAIL fetch_ack_width: got %b expected 1", ack_high);
    end
  endtask

  task automatic test_simultaneous();
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_write = 1'b1; d_size = 2'b10; d_addr = 32'h2000; d_wdata = 32'hCAFE_BABE;
    serve(0, $urandom, 1'b0);
    vectors++;
    if ({s_grant, s_addr, s_wdata, s_write} !== {2'b10, 32'h2000, 32'hCAFE_BABE, 1'b1}) begin
      miscompares++;
      $display("FAIL simul_data_first: got %b/%h/%h/%b expected 10/2000/cafebabe/1",
               s_grant, s_addr, s_wdata, s_write);
    end
    vectors++;
    if ({seen_d, seen_i, both_low, d_rdata} !== {3'b100, exp_d_rdata}) begin
      miscompares++;
      $display("FAIL simul_store_ack: got d=%b i=%b both=%b rdata=%h expected 1/0/0/%h",
               seen_d, seen_i, both_low, d_rdata, exp_d_rdata);
    end
    serve(0, 32'h0BAD_F00D, 1'b0);
    exp_i_rdata = 32'h0BAD_F00D;
    burst = 0;
    vectors++;
    if ({req_ticks, s_grant, s_addr, seen_i, i_rdata} !==
        {32'd1, 2'b01, 32'h300, 1'b1, exp_i_rdata}) begin
      miscompares++;
      $display("FAIL simul_fetch_next: got ticks=%0d g=%b a=%h i=%b rd=%h expected 1/01/300/1/%h",
               req_ticks, s_grant, s_addr, seen_i, i_rdata, exp_i_rdata);
    end
  endtask

  task automatic test_wait_states();
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b01; d_addr = 32'h4444;
    serve(5, 32'h55AA_55AA, 1'b0);
    exp_d_rdata = 32'h55AA_55AA;
    vectors++;
    if ({busy_cycles, stable, seen_err, ack_high} !== {32'd6, 3'b101}) begin
      miscompares++;
      $display("FAIL wait_states: got busy=%0d stable=%b err=%b ackhigh=%b expected 6/1/0/1",
               busy_cycles, stable, seen_err, ack_high);
    end
    vectors++;
    if ({s_size, d_rdata} !== {2'b01, exp_d_rdata}) begin
      miscompares++;
      $display("FAIL wait_rdata: got %b/%h expected 01/%h", s_size, d_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_deassert_mid();
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h88;
    serve(2, 32'h1234_5678, 1'b1);
    exp_d_rdata = 32'h1234_5678;
    vectors++;
    if ({seen_d, stable, d_rdata} !== {2'b11, exp_d_rdata}) begin
      miscompares++;
      $display("FAIL deassert_mid: got ack=%b stable=%b rd=%h expected 1/1/%h",
               seen_d, stable, d_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_timeout();
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h990;
    serve(100, 32'hFFFF_FFFF, 1'b0);
    exp_d_rdata = 32'h0;
    vectors++;
    if ({busy_cycles, seen_d, seen_err, stable, d_rdata, ack_high} !==
        {TO, 3'b111, exp_d_rdata, 1'b1}) begin
      miscompares++;
      $display("FAIL data_timeout: got busy=%0d ack=%b err=%b st=%b rd=%h hi=%b expected %0d/1/1/1/0/1",
               busy_cycles, seen_d, seen_err, stable, d_rdata, ack_high, TO);
    end
    i_req = 1'b1; i_addr = 32'h500;
    serve(100, 32'hFFFF_FFFF, 1'b0);
    exp_i_rdata = 32'h0;
    burst = 0;
    vectors++;
    if ({busy_cycles, seen_i, seen_err, i_rdata} !== {TO, 2'b11, exp_i_rdata}) begin
      miscompares++;
      $display("FAIL fetch_timeout: got busy=%0d ack=%b err=%b rd=%h expected %0d/1/1/0",
               busy_cycles, seen_i, seen_err, i_rdata, TO);
    end
  endtask

  task automatic test_reset_mid();
    logic [136:0] obs;
    logic quiet;
    int k;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h777;
    k = 0;
    while (!m_req && k < 4) begin
      tick();
      k++;
    end
    tick();
    rst = 1'b1;
    #1;
    obs = {m_req, m_write, bus_err, m_size, m_addr, m_wdata, i_rdata, d_rdata, grant,
           i_ack_n, d_ack_n};
    vectors++;
    if (obs !== {5'b0, 128'h0, 2'b00, 2'b11}) begin
      miscompares++;
      $display("FAIL reset_mid_values: got %h expected %h", obs, {5'b0, 128'h0, 2'b00, 2'b11});
    end
    exp_i_rdata = '0; exp_d_rdata = '0; burst = 0;
    tick();
    rst = 1'b0; d_req = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      if (!i_ack_n || !d_ack_n || bus_err || m_req) quiet = 1'b0;
      tick();
    end
    vectors++;
    if (quiet !== 1'b1) begin
      miscompares++; $display("FAIL reset_mid_no_ack: got %b expected 1", quiet);
    end
    i_req = 1'b1; i_addr = 32'hA0;
    serve(1, 32'h0000_00AA, 1'b0);
    exp_i_rdata = 32'h0000_00AA;
    vectors++;
    if ({req_ticks, busy_cycles, s_addr, i_rdata} !== {32'd1, 32'd2, 32'hA0, exp_i_rdata}) begin
      miscompares++;
      $display("FAIL reset_mid_recover: got %0d/%0d/%h/%h expected 1/2/a0/%h",
               req_ticks, busy_cycles, s_addr, i_rdata, exp_i_rdata);
    end
  endtask

  task automatic test_grant_sequence();
`ifdef ARB_STARVE_GUARD_EN
    logic [1:0] exp_g [6] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
`else
    logic [1:0] exp_g [3] = '{2'b10, 2'b10, 2'b10};
`endif
    logic [31:0] rd;
    i_req = 1'b1; i_addr = 32'hC0;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'hD0; d_wdata = 32'h5;
    foreach (exp_g[n]) begin
      rd = $urandom;
      serve(0, rd, 1'b0);
      if (s_grant == 2'b01) exp_i_rdata = rd;
      vectors++;
      if (s_grant !== exp_g[n]) begin
        miscompares++;
        $display("FAIL grant_seq[%0d]: got %b expected %b", n, s_grant, exp_g[n]);
      end
      if (n < $size(exp_g) - 1) begin
        i_req = 1'b1; i_addr = 32'hC0;
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'hD0; d_wdata = 32'h5;
      end
    end
    d_req = 1'b0;
    if (i_req) begin
      rd = $urandom;
      serve(0, rd, 1'b0);
      exp_i_rdata = rd;
    end
    burst = 0;
  endtask

  task automatic test_random();
    logic        exp_data, exp_wr, i_pend, tmo;
    logic [1:0]  exp_size;
    logic [31:0] exp_addr, exp_wdata, rd;
    int          waits;
    for (int n = 0; n < 60; n++) begin
      if (!i_req && ($urandom % 2 == 0)) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && (($urandom % 2 == 0) || !i_req)) begin
        d_req = 1'b1; d_write = 1'($urandom); d_size = 2'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      waits = ($urandom % 8 == 0) ? 100 : int'($urandom % 4);
      rd    = $urandom;
      // Arbitration rule: data first, except when the fetch has waited MB data grants.
      exp_data = d_req;
`ifdef ARB_STARVE_GUARD_EN
      if (i_req && burst == MB) exp_data = 1'b0;
`endif
      i_pend    = i_req;
      exp_wr    = exp_data ? d_write : 1'b0;
      exp_size  = exp_data ? d_size : 2'b10;
      exp_addr  = exp_data ? d_addr : i_addr;
      exp_wdata = d_wdata;
      tmo = (waits >= TO);
      serve(waits, rd, 1'b0);
      if (exp_data) begin
        if (!exp_wr) exp_d_rdata = tmo ? 32'h0 : rd;
        if (i_pend && burst < MB) burst++;
      end else begin
        exp_i_rdata = tmo ? 32'h0 : rd;
        burst = 0;
      end
      vectors++;
      if ({s_grant, s_addr, s_write, s_size} !==
          {(exp_data ? 2'b10 : 2'b01), exp_addr, exp_wr, exp_size}) begin
        miscompares++;
        $display("FAIL rand_bus[%0d]: got %b/%h/%b/%b expected %b/%h/%b/%b", n, s_grant,
                 s_addr, s_write, s_size, (exp_data ? 2'b10 : 2'b01), exp_addr, exp_wr,
                 exp_size);
      end
      vectors++;
      if (exp_data && exp_wr && (s_wdata !== exp_wdata)) begin
        miscompares++;
        $display("FAIL rand_wdata[%0d]: got %h expected %h", n, s_wdata, exp_wdata);
      end
      vectors++;
      if ({busy_cycles, seen_d, seen_i, seen_err, both_low, stable, ack_high} !==
          {(tmo ? TO : waits + 1), exp_data, !exp_data, tmo, 3'b011}) begin
        miscompares++;
        $display("FAIL rand_handshake[%0d]: got busy=%0d d=%b i=%b err=%b both=%b st=%b hi=%b",
                 n, busy_cycles, seen_d, seen_i, seen_err, both_low, stable, ack_high);
      end
      vectors++;
      if ({i_rdata, d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
        miscompares++;
        $display("FAIL rand_rdata[%0d]: got %h/%h expected %h/%h", n, i_rdata, d_rdata,
                 exp_i_rdata, exp_d_rdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_wait_states();
    test_deassert_mid();
    test_timeout();
    test_reset_mid();
    test_grant_sequence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified single-port memory bus between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sits between the core's split IAD/IDT/ACKI_n and DAD/DDT/MREQ/WRITE/SIZE/ACKD_n interfaces and the external memory.
- Returns per-requester active-low acks, so the core's existing interlock logic stalls unchanged.
- Sequences each transaction, prioritises data accesses and guards against a hung bus with a timeout.

Parameters:
- BUS_TIMEOUT, 255: max cycles waiting for m_ack_n after issue; 0 disables the timeout.
- MAX_DATA_BURST, 4: consecutive data grants allowed while a fetch waits; used only with ARB_STARVE_GUARD_EN.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ack_n low.
- i_addr  in  32  fetch address.
- i_rdata  out  32  fetched instruction; registered.
- i_ack_n  out  1  one-cycle low pulse = fetch complete.
- d_req  in  1  data request (MREQ); held until d_ack_n low.
- d_write  in  1  1 = store.
- d_size  in  2  access size, passed through unchanged.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; registered.
- d_ack_n  out  1  one-cycle low pulse = data access complete.
- m_req  out  1  bus request.
- m_write  out  1  bus write.
- m_size  out  2  bus size.
- m_addr  out  32  bus address.
- m_wdata  out  32  bus write data.
- m_rdata  in  32  bus read data.
- m_ack_n  in  1  bus ready, active low.
- grant  out  2  owner: 00 none, 01 IF, 10 MEM.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, rst=1) forces state IDLE and zeroes all counters. Output values:
  - m_req, m_write, bus_err = 0; m_size, m_addr, m_wdata = 0.
  - i_rdata, d_rdata = 0; grant = 00.
  - i_ack_n, d_ack_n = 1.
  - Reset mid-transaction abandons it silently, with no ack and no bus_err.
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE transitions:
  - d_req=1 -> D_BUSY; this also applies when i_req=1, so data wins.
  - Otherwise i_req=1 -> I_BUSY.
  - On entry, latch addr/size/write/wdata into m_* registers, assert m_req and set grant.
  - A fetch is always m_write=0 with m_size=2'b10 (word).
- x_BUSY, m_ack_n sampled 0:
  - Capture m_rdata into i_rdata (I_BUSY) or d_rdata (D_BUSY read only; stores leave d_rdata unchanged).
  - Drop m_req and m_write.
  - Drive the matching ack_n low for exactly the next cycle; go to RESP.
- RESP: ack_n returns high; grant=00; -> IDLE. No back-to-back grant, so the requester sees its ack before re-arbitration.
- Latency: request sampled in IDLE at cycle N, m_req high at N+1. If m_ack_n=0 at N+1, ack_n is low at N+2. Minimum 3 cycles per transaction.
- m_* outputs are stable for the whole of x_BUSY. Requester inputs changing mid-transaction are ignored. Deasserting x_req mid-transaction still completes the transaction and pulses its ack.
- Timeout (BUS_TIMEOUT>0): a wait counter clears on entry to x_BUSY and increments each cycle with m_ack_n=1. When it reaches BUS_TIMEOUT:
  - Terminate as a normal completion with read data forced to 0.
  - Pulse bus_err together with ack_n.
  - Counter width is $clog2(BUS_TIMEOUT+1).
- i_ack_n and d_ack_n are never low in the same cycle.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A saturating burst counter increments on each data grant made while i_req=1, and clears on any fetch grant.
  - When it equals MAX_DATA_BURST and i_req=1, IDLE grants IF even if d_req=1.
- Undefined: strict data priority; the counter and MAX_DATA_BURST logic are absent.

Decomposition:
- Package arb_pkg:
  - state enum (IDLE=2'd0, I_BUSY=2'd1, D_BUSY=2'd2, RESP=2'd3).
  - GRANT_NONE/GRANT_IF/GRANT_MEM constants.
  - SIZE_WORD=2'b10.
  - TIMEOUT_RDATA=32'h0.
- One sub-module, arb_wait_timer: BUS_TIMEOUT-parameterised wait counter with clear/enable inputs and an expired output.

Test Plan:
- Fetch only: i_req=1, i_addr=0x100, bus acks at first cycle, m_rdata=0x00000013 -> m_addr=0x100 and m_write=0 at N+1; i_ack_n low at N+2; i_rdata=0x00000013.
- Simultaneous: i_req=d_req=1, d_addr=0x2000, d_write=1, d_wdata=0xCAFEBABE -> data served first (grant=10, m_wdata=0xCAFEBABE, d_rdata unchanged), then fetch granted after RESP.
- Wait states: bus holds m_ack_n=1 for 5 cycles on a load of 0x55AA55AA -> m_* stable for 6 cycles; d_ack_n single-cycle low; d_rdata=0x55AA55AA; bus_err=0.
- Timeout with BUS_TIMEOUT=8 and m_ack_n stuck 1 -> after 8 wait cycles, ack_n and bus_err pulse together; rdata=0; state returns to IDLE.
- Reset mid D_BUSY: rst high for 1 cycle -> all outputs at reset values immediately; no ack pulse; next request proceeds normally.
- ARB_STARVE_GUARD_EN, MAX_DATA_BURST=2, d_req and i_req held high -> grant sequence MEM, MEM, IF, MEM, MEM, IF.
